// File: rtl/quad_pkg.sv
// Shared quadrature-state encodings and the per-update transition classifier.
// States are {a,b}; the forward (CW) order is 11 -> 01 -> 00 -> 10 -> 11.
package quad_pkg;

  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;

  localparam logic signed [3:0] ACC_DETENT = 4'sd4;

  typedef enum logic [1:0] {
    D_NONE,
    D_UP,
    D_DOWN,
    D_ILL
  } delta_t;

  function automatic delta_t quad_delta(input logic [1:0] prev, input logic [1:0] cur);
    delta_t d;
    d = D_NONE;
    if (prev != cur) begin
      // Gray sequence: both bits flipping at once cannot be a single legal step
      if ((prev ^ cur) == 2'b11) begin
        d = D_ILL;
      end else begin
        case (prev)
          ST_11:   d = (cur == ST_01) ? D_UP : D_DOWN;
          ST_01:   d = (cur == ST_00) ? D_UP : D_DOWN;
          ST_00:   d = (cur == ST_10) ? D_UP : D_DOWN;
          default: d = (cur == ST_11) ? D_UP : D_DOWN;
        endcase
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/quad_counter_glitch_filter.sv
// One encoder channel: 2-flop synchronizer, then a FILTER_LEN-deep sample history on tick.
// The level only moves when the whole history agrees; mixed histories hold the last level.
module glitch_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level
);

  logic [1:0]            sync_q, sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  level_q, level_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    hist_d  = hist_q;
    level_d = level_q;
    if (tick) begin
      hist_d = {hist_q[FILTER_LEN-2:0], sync_q[1]};
      if (&hist_d) begin
        level_d = 1'b1;
      end else if (~|hist_d) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      hist_q  <= {FILTER_LEN{1'b1}};
      level_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/quad_counter.sv
// Debounced rotary-encoder decoder driving a bounded (wrapping or saturating) position count.
// value/step/dir update one clk after the debounced pair returns to the 11 detent.
module quad_counter
  import quad_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int SAMPLE_DIV = 10,
  parameter int FILTER_LEN = 8,
  parameter int WRAP       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             clear_err,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [WIDTH-1:0] VMAX = {WIDTH{1'b1}};

  logic [SAMPLE_DIV-1:0] presc_q, presc_d;
  logic                  tick;
  logic                  a_db, b_db;
  logic [1:0]            ab_cur;
  delta_t                delta;
  logic signed [3:0]     delta_v, acc_sum;

  logic [1:0]        quad_q, quad_d;
  logic signed [2:0] acc_q, acc_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic              err_set;

  assign presc_d = presc_q + 1'b1;
  assign tick    = &presc_q;

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (a),
    .level (a_db)
  );

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .raw   (b),
    .level (b_db)
  );

  assign ab_cur  = {a_db, b_db};
  assign delta   = quad_delta(quad_q, ab_cur);
  assign delta_v = (delta == D_UP) ? 4'sd1 : (delta == D_DOWN) ? -4'sd1 : 4'sd0;
  assign acc_sum = $signed({acc_q[2], acc_q}) + delta_v;

  always_comb begin
    quad_d  = quad_q;
    acc_d   = acc_q;
    value_d = value_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    err_set = 1'b0;
    case (delta)
      D_ILL: begin
        err_set = 1'b1;
        acc_d   = 3'sd0;
        quad_d  = ab_cur;
      end
      D_UP, D_DOWN: begin
        quad_d = ab_cur;
        acc_d  = $signed(acc_sum[2:0]);
        if (ab_cur == ST_11) begin
          // Back at the detent: only a complete 4-transition turn counts
          acc_d = 3'sd0;
          if (acc_sum == ACC_DETENT) begin
            dir_d = 1'b1;
            if (WRAP != 0 || value_q != VMAX) begin
              value_d = value_q + 1'b1;
              step_d  = 1'b1;
            end
          end else if (acc_sum == -ACC_DETENT) begin
            dir_d = 1'b0;
            if (WRAP != 0 || value_q != '0) begin
              value_d = value_q - 1'b1;
              step_d  = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    err_d = clear_err ? 1'b0 : (err_q | err_set);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      quad_q  <= ST_11;
      acc_q   <= 3'sd0;
      value_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      quad_q  <= quad_d;
      acc_q   <= acc_d;
      value_q <= value_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign value = value_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_counter.sv
// Scoreboard bench: a wrapping and a saturating instance share the same encoder stimulus.
// The model tracks encoder position around the 4-state ring and counts whole turns.
module tb_quad_counter;

  localparam int W = 5;
  localparam int VMAX = 31;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         a = 1'b1;
  logic         b = 1'b1;
  logic         clear_err = 1'b0;
  logic [W-1:0] value_w, value_s;
  logic         step_w, step_s, dir_w, dir_s, err_w, err_s;

  quad_counter #(.WIDTH(W), .SAMPLE_DIV(2), .FILTER_LEN(3), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .a(a), .b(b), .clear_err(clear_err),
    .value(value_w), .step(step_w), .dir(dir_w), .err(err_w)
  );

  quad_counter #(.WIDTH(W), .SAMPLE_DIV(2), .FILTER_LEN(3), .WRAP(0)) dut_s (
    .clk(clk), .reset(reset), .a(a), .b(b), .clear_err(clear_err),
    .value(value_s), .step(step_s), .dir(dir_s), .err(err_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int value;
    int dir;
  } ev_t;

  ev_t q_w[$];
  ev_t q_s[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model state: encoder ring position, progress since last detent
  int m_state = 3;
  int m_acc   = 0;
  int m_vw    = 0;
  int m_vs    = 0;
  int m_dw    = 0;
  int m_ds    = 0;
  int m_err   = 0;

  function automatic int pos(input int ab);
    case (ab)
      3: return 0;
      1: return 1;
      0: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int ring(input int p);
    case (p % 4)
      0: return 3;
      1: return 1;
      2: return 0;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int ab);
    int d;
    ev_t e;
    if (ab == m_state) return;
    d = (pos(ab) - pos(m_state) + 4) % 4;
    m_state = ab;
    if (d == 2) begin
      if (!clear_err) m_err = 1;
      m_acc = 0;
      return;
    end
    m_acc += (d == 1) ? 1 : -1;
    if (ab == 3) begin
      if (m_acc == 4) begin
        m_vw = (m_vw + 1) % (VMAX + 1);
        m_dw = 1;
        e.value = m_vw; e.dir = 1; q_w.push_back(e);
        m_ds = 1;
        if (m_vs < VMAX) begin
          m_vs++;
          e.value = m_vs; q_s.push_back(e);
        end
      end else if (m_acc == -4) begin
        m_vw = (m_vw + VMAX) % (VMAX + 1);
        m_dw = 0;
        e.value = m_vw; e.dir = 0; q_w.push_back(e);
        m_ds = 0;
        if (m_vs > 0) begin
          m_vs--;
          e.value = m_vs; q_s.push_back(e);
        end
      end
      m_acc = 0;
    end
  endtask

  task automatic move(input int ab, input int hold);
    @(negedge clk);
    a = ab[1];
    b = ab[0];
    model_step(ab);
    repeat (hold) @(negedge clk);
  endtask

  task automatic fwd_detent();
    move(1, 40); move(0, 40); move(2, 40); move(3, 40);
  endtask

  task automatic rev_detent();
    move(2, 40); move(0, 40); move(1, 40); move(3, 40);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, " value_w"}, int'(value_w), m_vw);
    check({tag, " value_s"}, int'(value_s), m_vs);
    check({tag, " dir_w"}, int'(dir_w), m_dw);
    check({tag, " dir_s"}, int'(dir_s), m_ds);
    check({tag, " err_w"}, int'(err_w), m_err);
    check({tag, " err_s"}, int'(err_s), m_err);
    check({tag, " pending_w"}, q_w.size(), 0);
    check({tag, " pending_s"}, q_s.size(), 0);
  endtask

  // Monitor: every step pulse must match the oldest expected detent
  always @(negedge clk) begin
    if (!reset) begin
      if (step_w) begin
        ev_t e;
        if (q_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL step_w unexpected pulse value %0d", value_w);
        end else begin
          e = q_w.pop_front();
          check("step_w value", int'(value_w), e.value);
          check("step_w dir", int'(dir_w), e.dir);
        end
      end
      if (step_s) begin
        ev_t e;
        if (q_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL step_s unexpected pulse value %0d", value_s);
        end else begin
          e = q_s.pop_front();
          check("step_s value", int'(value_s), e.value);
          check("step_s dir", int'(dir_s), e.dir);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset step_w", int'(step_w), 0);
    check("reset value_w", int'(value_w), 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checkpoint("idle");

    fwd_detent();
    checkpoint("fwd");
    check("fwd value", int'(value_w), 1);
    rev_detent();
    checkpoint("rev");

    // Lows of 8 clk span exactly two filter samples
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 1'b0;
      repeat (8) @(negedge clk);
      a = 1'b1;
      repeat (30) @(negedge clk);
    end
    checkpoint("glitch");

    move(1, 40); move(0, 40); move(1, 40); move(3, 40);
    checkpoint("partial");

    move(0, 40);
    checkpoint("illegal");
    check("illegal err", int'(err_w), 1);
    @(negedge clk);
    clear_err = 1'b1;
    m_err = 0;
    @(negedge clk);
    clear_err = 1'b0;
    repeat (5) @(negedge clk);
    checkpoint("clear");

    // Clear held across the cycles where illegal jumps land
    clear_err = 1'b1;
    move(3, 40);
    move(0, 40);
    move(2, 40);
    move(3, 40);
    clear_err = 1'b0;
    repeat (5) @(negedge clk);
    checkpoint("clear_vs_set");

    rev_detent();
    checkpoint("underflow");
    check("underflow wrap", int'(value_w), 31);
    check("underflow sat", int'(value_s), 0);

    for (int i = 0; i < 33; i++) fwd_detent();
    checkpoint("overflow");
    check("overflow sat", int'(value_s), 31);

    for (int i = 0; i < 80; i++) begin
      int r;
      int p;
      int nxt;
      r = $urandom_range(0, 99);
      p = pos(m_state);
      if (r < 10) nxt = m_state ^ 3;
      else if (r < 55) nxt = ring(p + 1);
      else nxt = ring(p + 3);
      move(nxt, $urandom_range(30, 50));
    end
    checkpoint("random");

    move(1, 40);
    move(0, 40);
    @(negedge clk);
    reset = 1'b1;
    a = 1'b1;
    b = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset value_w", int'(value_w), 0);
    check("midreset err_w", int'(err_w), 0);
    reset = 1'b0;
    m_state = 3; m_acc = 0; m_vw = 0; m_vs = 0;
    m_dw = 0; m_ds = 0; m_err = 0;
    q_w.delete();
    q_s.delete();
    repeat (40) @(negedge clk);
    checkpoint("post_reset");
    fwd_detent();
    checkpoint("post_reset_fwd");
    check("post_reset value", int'(value_w), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
